// File: rtl/sc_alu_seq_pkg.sv
// Shared constants for the sequential ALU: opcodes, FSM encoding and flag bit positions.
package sc_alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_PASA = 4'd6;
  localparam logic [3:0] OP_PASB = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flags_t;

endpackage

// File: rtl/sc_alu_seq_if.sv
// Control-unit / datapath side of the sequential ALU: operand buses, opcode, handshake and flags.
interface sc_alu_seq_if #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int DATAWIDTH_OP  = 4
);
  logic [DATAWIDTH_BUS-1:0] SC_ALUSeq_DataBUS_In_A;
  logic [DATAWIDTH_BUS-1:0] SC_ALUSeq_DataBUS_In_B;
  logic [DATAWIDTH_OP-1:0]  SC_ALUSeq_OP_In;
  logic                     SC_ALUSeq_Start_In;
  logic                     SC_ALUSeq_ENABLE_BUS_C;
  logic                     SC_ALUSeq_Busy_Out;
  logic                     SC_ALUSeq_Done_Out;
  logic [3:0]               SC_ALUSeq_Flags_Out;

  modport master (
    output SC_ALUSeq_DataBUS_In_A, SC_ALUSeq_DataBUS_In_B, SC_ALUSeq_OP_In,
           SC_ALUSeq_Start_In, SC_ALUSeq_ENABLE_BUS_C,
    input  SC_ALUSeq_Busy_Out, SC_ALUSeq_Done_Out, SC_ALUSeq_Flags_Out
  );

  modport slave (
    input  SC_ALUSeq_DataBUS_In_A, SC_ALUSeq_DataBUS_In_B, SC_ALUSeq_OP_In,
           SC_ALUSeq_Start_In, SC_ALUSeq_ENABLE_BUS_C,
    output SC_ALUSeq_Busy_Out, SC_ALUSeq_Done_Out, SC_ALUSeq_Flags_Out
  );

endinterface

// File: rtl/sc_alu_seq_core.sv
// Combinational single-step datapath: adder/logic unit, one-bit shift step and one shift-add multiply step.
module sc_alu_seq_core
  import sc_alu_seq_pkg::*;
#(
  parameter int DATAWIDTH_BUS = 32,
  parameter int DATAWIDTH_OP  = 4
) (
  input  logic [DATAWIDTH_OP-1:0]  i_op,
  input  logic [DATAWIDTH_BUS-1:0] i_a,
  input  logic [DATAWIDTH_BUS-1:0] i_b,
  input  logic [DATAWIDTH_BUS-1:0] i_work,
  input  logic                     i_shift_en,
  output logic [DATAWIDTH_BUS-1:0] o_res,
  output logic [DATAWIDTH_BUS-1:0] o_a_nxt,
  output logic [DATAWIDTH_BUS-1:0] o_b_nxt,
  output logic                     o_c,
  output logic                     o_v
);

  logic                     w_sub;
  logic [DATAWIDTH_BUS-1:0] w_b_add;
  logic [DATAWIDTH_BUS:0]   w_sum;

  // SUB is A + ~B + 1, so carry means "no borrow" and one overflow rule covers both ops
  assign w_sub   = (i_op == OP_SUB);
  assign w_b_add = w_sub ? ~i_b : i_b;
  assign w_sum   = {1'b0, i_a} + {1'b0, w_b_add} + {{DATAWIDTH_BUS{1'b0}}, w_sub};

  always_comb begin
    o_res   = '0;
    o_c     = 1'b0;
    o_v     = 1'b0;
    o_a_nxt = i_a << 1;
    o_b_nxt = i_b >> 1;
    case (i_op)
      OP_ADD, OP_SUB: begin
        o_res = w_sum[DATAWIDTH_BUS-1:0];
        o_c   = w_sum[DATAWIDTH_BUS];
        o_v   = (i_a[DATAWIDTH_BUS-1] == w_b_add[DATAWIDTH_BUS-1]) &&
                (w_sum[DATAWIDTH_BUS-1] != i_a[DATAWIDTH_BUS-1]);
      end
      OP_AND:  o_res = i_a & i_b;
      OP_OR:   o_res = i_a | i_b;
      OP_XOR:  o_res = i_a ^ i_b;
      OP_NOT:  o_res = ~i_a;
      OP_PASA: o_res = i_a;
      OP_PASB: o_res = i_b;
      OP_SLL: begin
        o_res = i_shift_en ? (i_work << 1) : i_work;
        o_c   = i_shift_en & i_work[DATAWIDTH_BUS-1];
      end
      OP_SRL: begin
        o_res = i_shift_en ? (i_work >> 1) : i_work;
        o_c   = i_shift_en & i_work[0];
      end
      OP_SRA:  o_res = i_shift_en ? {i_work[DATAWIDTH_BUS-1], i_work[DATAWIDTH_BUS-1:1]} : i_work;
      OP_MUL:  o_res = i_work + (i_b[0] ? i_a : '0);
      default: o_res = '0;
    endcase
  end

endmodule

// File: rtl/sc_alu_seq.sv
// Multi-cycle ALU: latches operands on Start, iterates shifts/multiply on falling edges, drives bus C tri-state.
module sc_alu_seq
  import sc_alu_seq_pkg::*;
#(
  parameter int DATAWIDTH_BUS   = 32,
  parameter int DATAWIDTH_OP    = 4,
  parameter int DATAWIDTH_SHAMT = 5
) (
  input  logic                     SC_ALUSeq_CLOCK_50,
  input  logic                     SC_ALUSeq_Reset_InHigh,
  sc_alu_seq_if.slave              bus,
  output wire [DATAWIDTH_BUS-1:0]  SC_ALUSeq_DataBUS_Out_C
);

  logic [1:0]                 r_state;
  logic [DATAWIDTH_OP-1:0]    r_op;
  logic [DATAWIDTH_BUS-1:0]   r_a;
  logic [DATAWIDTH_BUS-1:0]   r_b;
  logic [DATAWIDTH_BUS-1:0]   r_work;
  logic [DATAWIDTH_BUS-1:0]   r_result;
  logic [DATAWIDTH_SHAMT-1:0] r_cnt;
  flags_t                     r_flags;

  logic [DATAWIDTH_BUS-1:0]   w_res;
  logic [DATAWIDTH_BUS-1:0]   w_a_nxt;
  logic [DATAWIDTH_BUS-1:0]   w_b_nxt;
  logic                       w_c;
  logic                       w_v;
  logic                       w_shift_en;
  logic                       w_reserved;
  logic                       w_start_is_shift;
  logic [DATAWIDTH_SHAMT-1:0] w_start_shamt;
  logic [DATAWIDTH_SHAMT-1:0] w_cnt_init;
  flags_t                     w_flags;

  assign w_shift_en = |r_b[DATAWIDTH_SHAMT-1:0];
  assign w_reserved = (r_op > OP_MUL);

  sc_alu_seq_core #(
    .DATAWIDTH_BUS (DATAWIDTH_BUS),
    .DATAWIDTH_OP  (DATAWIDTH_OP)
  ) u_core (
    .i_op       (r_op),
    .i_a        (r_a),
    .i_b        (r_b),
    .i_work     (r_work),
    .i_shift_en (w_shift_en),
    .o_res      (w_res),
    .o_a_nxt    (w_a_nxt),
    .o_b_nxt    (w_b_nxt),
    .o_c        (w_c),
    .o_v        (w_v)
  );

  // Step count minus one: a zero shift amount still takes one pass-through step
  assign w_start_shamt    = bus.SC_ALUSeq_DataBUS_In_B[DATAWIDTH_SHAMT-1:0];
  assign w_start_is_shift = (bus.SC_ALUSeq_OP_In == OP_SLL) || (bus.SC_ALUSeq_OP_In == OP_SRL) ||
                            (bus.SC_ALUSeq_OP_In == OP_SRA);

  always_comb begin
    w_cnt_init = '0;
    if (bus.SC_ALUSeq_OP_In == OP_MUL)
      w_cnt_init = '1;
    else if (w_start_is_shift && (w_start_shamt != '0))
      w_cnt_init = w_start_shamt - 1'b1;
  end

  always_comb begin
    w_flags = '0;
    if (!w_reserved) begin
      w_flags[FLAG_N] = w_res[DATAWIDTH_BUS-1];
      w_flags[FLAG_Z] = (w_res == '0);
      w_flags[FLAG_C] = w_c;
      w_flags[FLAG_V] = w_v;
    end
  end

  always_ff @(negedge SC_ALUSeq_CLOCK_50 or posedge SC_ALUSeq_Reset_InHigh) begin
    if (SC_ALUSeq_Reset_InHigh) begin
      r_state  <= ST_IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_work   <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_flags  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.SC_ALUSeq_Start_In) begin
            r_op    <= bus.SC_ALUSeq_OP_In;
            r_a     <= bus.SC_ALUSeq_DataBUS_In_A;
            r_b     <= bus.SC_ALUSeq_DataBUS_In_B;
            r_work  <= (bus.SC_ALUSeq_OP_In == OP_MUL) ? '0 : bus.SC_ALUSeq_DataBUS_In_A;
            r_cnt   <= w_cnt_init;
            r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_work <= w_res;
          r_cnt  <= r_cnt - 1'b1;
          if (r_op == OP_MUL) begin
            r_a <= w_a_nxt;
            r_b <= w_b_nxt;
          end
          if (r_cnt == '0) begin
            r_result <= w_res;
            r_flags  <= w_flags;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.SC_ALUSeq_Busy_Out  = (r_state == ST_CALC) || (r_state == ST_DONE);
  assign bus.SC_ALUSeq_Done_Out  = (r_state == ST_DONE);
  assign bus.SC_ALUSeq_Flags_Out = r_flags;

  assign SC_ALUSeq_DataBUS_Out_C = bus.SC_ALUSeq_ENABLE_BUS_C ? r_result : {DATAWIDTH_BUS{1'bz}};

endmodule
